kmap_lut_engine: RTL

Parametrised, clocked successor to the team's fixed 4-input gate-level K-map blocks. Holds an N_IN-input Boolean function as a runtime-writable truth table, evaluates input vectors over a valid/ready stream with one register stage, and runs a self-scan that walks every minterm and reports the on-set size. It sits in the lab datapath wherever a reconfigurable small logic function replaces a hard-wired gate network.

---
 rtl/kmap_lut_engine_if.sv | 31 +++
 rtl/kmap_lut_engine.sv | 123 ++++++++++++
 2 files changed

// File: rtl/kmap_lut_engine_if.sv
// Bus bundle for kmap_lut_engine: table-write port, eval stream and scan control.
// Eval stream: a beat transfers on a rising edge where valid && ready; the producer holds
// its payload stable while valid && !ready, and ready may depend combinationally on the
// consumer's ready but never on valid.
interface kmap_lut_engine_if #(
    parameter int N_IN = 4
) ();
    logic            cfg_we;
    logic [N_IN-1:0] cfg_addr;
    logic            cfg_data;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            in_ready;
    logic            out_valid;
    logic            out_bit;
    logic            out_ready;
    logic            scan_start;
    logic            scan_busy;
    logic            scan_done;
    logic [N_IN:0]   minterm_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_vec, out_ready, scan_start,
        input  in_ready, out_valid, out_bit, scan_busy, scan_done, minterm_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_vec, out_ready, scan_start,
        output in_ready, out_valid, out_bit, scan_busy, scan_done, minterm_cnt
    );
endinterface

// File: rtl/kmap_lut_engine.sv
// Runtime-writable N_IN-input truth table with a one-stage eval stream and a
// minterm-counting self-scan; dbg_state exposes the scan FSM.
module kmap_lut_engine #(
    parameter int                   N_IN = 4,
    parameter logic [(1<<N_IN)-1:0] INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    kmap_lut_engine_if.slave       bus,
    output logic [1:0]             dbg_state
);
    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] table_q, table_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [N_IN:0]    acc_q, acc_d;
    logic [N_IN:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             in_ready;
    logic             xfer;
    logic             table_we;
    logic [N_IN:0]    acc_next;

    assign in_ready = !busy_q && (!out_valid_q || bus.out_ready);
    assign xfer     = bus.in_valid && in_ready;
    assign table_we = bus.cfg_we && (state_q != S_SCAN);
    // Accumulator is one bit wider than the index so a full on-set does not wrap.
    assign acc_next = acc_q + {{N_IN{1'b0}}, table_q[idx_q]};

    always_comb begin
        table_d = table_q;
        if (table_we) begin
            table_d[bus.cfg_addr] = bus.cfg_data;
        end

        // Eval reads table_q, so a same-cycle write to the same entry returns the old value.
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_bit_d   = table_q[bus.in_vec];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.scan_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                acc_d  = acc_next;
                idx_d  = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
                busy_d = 1'b1;
                // Terminal on the all-ones index; the count lands as DONE is entered.
                if (idx_q == {N_IN{1'b1}}) begin
                    state_d = S_DONE;
                    cnt_d   = acc_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q     <= INIT;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            table_q     <= table_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_bit     = out_bit_q;
    assign bus.scan_busy   = busy_q;
    assign bus.scan_done   = done_q;
    assign bus.minterm_cnt = cnt_q;
    assign dbg_state       = state_q;
endmodule
